// File: rtl/calc_pkg.sv
// Shared definitions for the calculator issue controller: default opcodes and
// latencies, the sequencer state encoding and the one-hot unit-select decode.
package calc_pkg;

  localparam logic [3:0] MUL_OP_DEFAULT  = 4'h2;
  localparam logic [3:0] DIV_OP_DEFAULT  = 4'h3;
  localparam int         MUL_LAT_DEFAULT = 4;
  localparam int         DIV_LAT_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [15:0] onehot16(input logic [3:0] opcode);
    return 16'b1 << opcode;
  endfunction

endpackage

// File: rtl/calc_op_sequencer.sv
// Issue controller: accepts one op, drives the unit select for its latency,
// captures the result and returns it. Optional macro: CALC_DIVZERO_CHK_EN.
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int         WIDTH   = 16,
  parameter logic [3:0] MUL_OP  = MUL_OP_DEFAULT,
  parameter logic [3:0] DIV_OP  = DIV_OP_DEFAULT,
  parameter int         MUL_LAT = MUL_LAT_DEFAULT,
  parameter int         DIV_LAT = DIV_LAT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_opcode,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [15:0]      dp_hotselect,
  output logic             dp_start,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  input  logic [WIDTH-1:0] dp_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err,
  output logic             busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       opcode_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_load;
  logic             start_q;
  logic             accept;
  logic             div_zero;

  assign accept = req_valid && req_ready;

`ifdef CALC_DIVZERO_CHK_EN
  assign div_zero = (req_opcode == DIV_OP) && (req_b == '0);
`else
  assign div_zero = 1'b0;
`endif

  always_comb begin
    cnt_load = '0;
    if (req_opcode == MUL_OP) begin
      cnt_load = CNT_W'(MUL_LAT - 1);
    end else if (req_opcode == DIV_OP) begin
      cnt_load = CNT_W'(DIV_LAT - 1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = div_zero ? RESP : EXEC;
      EXEC: if (cnt == '0) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand latch, latency counter and result capture on the final EXEC cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      opcode_q   <= '0;
      dp_a       <= '0;
      dp_b       <= '0;
      cnt        <= '0;
      start_q    <= 1'b0;
      rsp_result <= '0;
    end else begin
      start_q <= 1'b0;
      if (accept) begin
        opcode_q <= req_opcode;
        dp_a     <= req_a;
        dp_b     <= req_b;
        cnt      <= cnt_load;
        start_q  <= !div_zero;
        if (div_zero) begin
          rsp_result <= '0;
        end
      end else if (state == EXEC) begin
        if (cnt == '0) begin
          rsp_result <= dp_result;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

`ifdef CALC_DIVZERO_CHK_EN
  logic rsp_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_err_q <= 1'b0;
    end else if (accept) begin
      rsp_err_q <= div_zero;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign req_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign rsp_valid    = (state == RESP);
  assign dp_start     = start_q;
  assign dp_hotselect = (state == EXEC) ? onehot16(opcode_q) : 16'h0000;

endmodule
